// File: rtl/step_staircase_gen.sv
// step_staircase_gen: turns a 4-bit stair count into a repeating staircase DAC
// code of N = min(steps,10) equal levels. Each level is held TICKS_PER_STEP
// cycles. The current stair index is also shown as a one-hot LED vector.
// Optional macro STEP_TRIANGLE_MODE_EN makes the staircase run up then down
// (0..N-1..1) instead of the default sawtooth.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   steps[3:0]     requested stair count (11..15 are treated as 10)
//   enable         level-sensitive run request
//   level[DAC_WIDTH-1:0]  registered staircase code, (step_idx+1)*STEP
//   step_idx[3:0]  registered stair index, 0..N-1
//   led[9:0]       registered one-hot of step_idx, 0 when idle
//   wrap           registered one-cycle pulse when the staircase restarts at 0
module step_staircase_gen #(
   parameter int unsigned TICKS_PER_STEP = 100000000,
   parameter int unsigned DAC_WIDTH      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           steps,
   input  logic                 enable,
   output logic [DAC_WIDTH-1:0] level,
   output logic [3:0]           step_idx,
   output logic [9:0]           led,
   output logic                 wrap
);

   localparam int unsigned TICK_W   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam int unsigned PROD_W   = DAC_WIDTH + 4;
   localparam int unsigned MAX_CODE = (1 << DAC_WIDTH) - 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_n;
   logic [TICK_W-1:0]    tick, tick_n;
   logic [3:0]           n_lat, n_n;
   logic [3:0]           idx_n;
   logic [DAC_WIDTH-1:0] level_n;
   logic [9:0]           led_n;
   logic                 wrap_n;
   logic                 boundary;
   logic [3:0]           steps_clamped;
`ifdef STEP_TRIANGLE_MODE_EN
   logic                 dir_down, dir_down_n;
`endif

   // Constant step-size table: floor(MAX_CODE / N)
   function automatic logic [DAC_WIDTH-1:0] step_for(input logic [3:0] n);
      case (n)
         4'd1:    return DAC_WIDTH'(MAX_CODE / 1);
         4'd2:    return DAC_WIDTH'(MAX_CODE / 2);
         4'd3:    return DAC_WIDTH'(MAX_CODE / 3);
         4'd4:    return DAC_WIDTH'(MAX_CODE / 4);
         4'd5:    return DAC_WIDTH'(MAX_CODE / 5);
         4'd6:    return DAC_WIDTH'(MAX_CODE / 6);
         4'd7:    return DAC_WIDTH'(MAX_CODE / 7);
         4'd8:    return DAC_WIDTH'(MAX_CODE / 8);
         4'd9:    return DAC_WIDTH'(MAX_CODE / 9);
         4'd10:   return DAC_WIDTH'(MAX_CODE / 10);
         default: return '0;
      endcase
   endfunction

   assign steps_clamped = (steps > 4'd10) ? 4'd10 : steps;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tick     <= '0;
         n_lat    <= '0;
         step_idx <= '0;
         level    <= '0;
         led      <= '0;
         wrap     <= 1'b0;
`ifdef STEP_TRIANGLE_MODE_EN
         dir_down <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         tick     <= tick_n;
         n_lat    <= n_n;
         step_idx <= idx_n;
         level    <= level_n;
         led      <= led_n;
         wrap     <= wrap_n;
`ifdef STEP_TRIANGLE_MODE_EN
         dir_down <= dir_down_n;
`endif
      end
   end

   // Next-state, index sequencing and next output values
   always_comb begin
      state_n  = state;
      tick_n   = tick;
      n_n      = n_lat;
      idx_n    = step_idx;
      wrap_n   = 1'b0;
      boundary = 1'b0;
`ifdef STEP_TRIANGLE_MODE_EN
      dir_down_n = dir_down;
`endif

      case (state)
         IDLE: begin
            if (enable && (steps != 4'd0)) begin
               state_n = RUN;
               n_n     = steps_clamped;
               idx_n   = 4'd0;
               tick_n  = '0;
`ifdef STEP_TRIANGLE_MODE_EN
               dir_down_n = 1'b0;
`endif
            end
         end
         RUN: begin
            if (!enable) begin
               state_n = IDLE;
            end else if (tick != TICK_LAST) begin
               tick_n = tick + TICK_W'(1);
            end else begin
               tick_n = '0;
`ifdef STEP_TRIANGLE_MODE_EN
               // Turn at the top without repeating it; any move back into
               // index 0 is the restart point (covers N=1 and N=2 too).
               if (!dir_down) begin
                  if (step_idx < n_lat - 4'd1) begin
                     idx_n = step_idx + 4'd1;
                  end else if (n_lat >= 4'd3) begin
                     dir_down_n = 1'b1;
                     idx_n      = n_lat - 4'd2;
                  end else begin
                     boundary = 1'b1;
                  end
               end else begin
                  if (step_idx > 4'd1) idx_n = step_idx - 4'd1;
                  else                 boundary = 1'b1;
               end
`else
               if (step_idx < n_lat - 4'd1) idx_n = step_idx + 4'd1;
               else                         boundary = 1'b1;
`endif
               // steps is only resampled here so each period is glitch-free
               if (boundary) begin
                  if (steps == 4'd0) begin
                     state_n = IDLE;
                  end else begin
                     n_n    = steps_clamped;
                     idx_n  = 4'd0;
                     wrap_n = 1'b1;
`ifdef STEP_TRIANGLE_MODE_EN
                     dir_down_n = 1'b0;
`endif
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n == IDLE) begin
         tick_n = '0;
         n_n    = 4'd0;
         idx_n  = 4'd0;
`ifdef STEP_TRIANGLE_MODE_EN
         dir_down_n = 1'b0;
`endif
      end

      // Product never exceeds MAX_CODE, so truncation is lossless
      level_n = (state_n == RUN)
              ? DAC_WIDTH'(PROD_W'(idx_n + 4'd1) * PROD_W'(step_for(n_n)))
              : '0;
      led_n   = (state_n == RUN) ? (10'd1 << idx_n) : 10'd0;
   end

endmodule

// File: tb/tb_step_staircase_gen.sv
// Self-checking bench for step_staircase_gen with TICKS_PER_STEP=4, DAC_WIDTH=8.
module tb_step_staircase_gen;

   localparam int unsigned TICKS = 4;
   localparam int unsigned DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    steps;
   logic          enable;
   logic [DW-1:0] level;
   logic [3:0]    step_idx;
   logic [9:0]    led;
   logic          wrap;

   int total  = 0;
   int passed = 0;

   step_staircase_gen #(.TICKS_PER_STEP(TICKS), .DAC_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .steps(steps), .enable(enable),
      .level(level), .step_idx(step_idx), .led(led), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      enable = 1'b0;
      steps  = 4'd0;
      step();
      step();
   endtask

   function automatic logic [22:0] pack_exp(int lvl, int idx, logic on, logic wr);
      logic [9:0] l;
      l = on ? 10'(1 << idx) : 10'd0;
      return {8'(lvl), 4'(idx), l, wr};
   endfunction

   task automatic test_reset();
      logic [22:0] got, exp;
      rst_n = 1'b0; enable = 1'b0; steps = 4'd0;
      step(); step();
      rst_n = 1'b1;
      step();
      got = {level, step_idx, led, wrap}; exp = '0; total++;
      if (got !== exp) $display("FAIL reset_idle got=%h exp=%h", got, exp); else passed++;
      steps = 4'd4; enable = 1'b1;
      for (int i = 0; i < 6; i++) step();
      got = {level, step_idx, led, wrap}; exp = pack_exp(126, 1, 1'b1, 1'b0); total++;
      if (got !== exp) $display("FAIL reset_prerun got=%h exp=%h", got, exp); else passed++;
      #2 rst_n = 1'b0;
      #1;
      got = {level, step_idx, led, wrap}; exp = '0; total++;
      if (got !== exp) $display("FAIL reset_async got=%h exp=%h", got, exp); else passed++;
      enable = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         got = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, exp); else passed++;
      end
   endtask

   task automatic test_n1();
      logic [22:0] got, exp;
      go_idle();
      steps = 4'd1; enable = 1'b1;
      step();
      for (int k = 0; k <= 12; k++) begin
         exp = pack_exp(255, 0, 1'b1, (k > 0) && (k % 4 == 0));
         got = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL n1[%0d] got=%h exp=%h", k, got, exp); else passed++;
         step();
      end
   endtask

   task automatic test_disable();
      logic [22:0] got, exp;
      go_idle();
      steps = 4'd4; enable = 1'b1;
      step();
      for (int i = 0; i < 8; i++) step();
      got = {level, step_idx, led, wrap}; exp = pack_exp(189, 2, 1'b1, 1'b0); total++;
      if (got !== exp) $display("FAIL dis_idx2 got=%h exp=%h", got, exp); else passed++;
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         got = {level, step_idx, led, wrap}; exp = '0; total++;
         if (got !== exp) $display("FAIL dis_idle[%0d] got=%h exp=%h", i, got, exp); else passed++;
      end
      enable = 1'b1;
      step();
      got = {level, step_idx, led, wrap}; exp = pack_exp(63, 0, 1'b1, 1'b0); total++;
      if (got !== exp) $display("FAIL dis_restart got=%h exp=%h", got, exp); else passed++;
   endtask

`ifndef STEP_TRIANGLE_MODE_EN
   task automatic test_saw4();
      logic [22:0] got, exp;
      int idx;
      go_idle();
      steps = 4'd4; enable = 1'b1;
      step();
      for (int k = 0; k <= 20; k++) begin
         idx = (k / 4) % 4;
         exp = pack_exp((idx + 1) * 63, idx, 1'b1, (k > 0) && (k % 16 == 0));
         got = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL saw4[%0d] got=%h exp=%h", k, got, exp); else passed++;
         step();
      end
   endtask

   task automatic test_clamp();
      logic [22:0] got, exp;
      int idx;
      for (int s = 0; s < 2; s++) begin
         go_idle();
         steps = (s == 0) ? 4'd10 : 4'd15; enable = 1'b1;
         step();
         for (int k = 0; k <= 44; k++) begin
            idx = (k / 4) % 10;
            exp = pack_exp((idx + 1) * 25, idx, 1'b1, (k > 0) && (k % 40 == 0));
            got = {level, step_idx, led, wrap}; total++;
            if (got !== exp) $display("FAIL clamp_s%0d[%0d] got=%h exp=%h", steps, k, got, exp);
            else passed++;
            step();
         end
      end
   endtask

   task automatic test_change();
      logic [22:0] got, exp;
      int idx, lvl;
      go_idle();
      steps = 4'd4; enable = 1'b1;
      step();
      for (int k = 0; k <= 27; k++) begin
         if (k < 16) begin idx = (k / 4) % 4;        lvl = (idx + 1) * 63;  end
         else        begin idx = ((k - 16) / 4) % 2; lvl = (idx + 1) * 127; end
         exp = pack_exp(lvl, idx, 1'b1, (k == 16) || (k == 24));
         got = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL change[%0d] got=%h exp=%h", k, got, exp); else passed++;
         if (k == 4) steps = 4'd2;
         step();
      end
   endtask

   task automatic test_zero_at_wrap();
      logic [22:0] got, exp;
      int idx;
      go_idle();
      steps = 4'd4; enable = 1'b1;
      step();
      for (int k = 0; k <= 19; k++) begin
         idx = (k / 4) % 4;
         exp = (k < 16) ? pack_exp((idx + 1) * 63, idx, 1'b1, 1'b0) : 23'd0;
         got = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL zero_wrap[%0d] got=%h exp=%h", k, got, exp); else passed++;
         if (k == 5) steps = 4'd0;
         step();
      end
   endtask
`else
   task automatic test_triangle();
      logic [22:0] got, exp;
      int slot, idx;
      go_idle();
      steps = 4'd3; enable = 1'b1;
      step();
      for (int k = 0; k <= 36; k++) begin
         slot = (k / 4) % 4;
         idx  = (slot == 3) ? 1 : slot;
         exp  = pack_exp((idx + 1) * 85, idx, 1'b1, (k > 0) && (k % 16 == 0));
         got  = {level, step_idx, led, wrap}; total++;
         if (got !== exp) $display("FAIL tri3[%0d] got=%h exp=%h", k, got, exp); else passed++;
         step();
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; enable = 1'b0; steps = 4'd0;
      test_reset();
`ifndef STEP_TRIANGLE_MODE_EN
      test_saw4();
      test_clamp();
      test_change();
      test_zero_at_wrap();
`else
      test_triangle();
`endif
      test_disable();
      test_n1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
